// File: rtl/hack_alu_pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hack_alu_pkg : control-word bit indices, named opcodes, multiply FSM state.
// Rev 1.0
// ----------------------------------------------------------------------------
package hack_alu_pkg;

  localparam int OP_ZX = 5;
  localparam int OP_NX = 4;
  localparam int OP_ZY = 3;
  localparam int OP_NY = 2;
  localparam int OP_F  = 1;
  localparam int OP_NO = 0;

  localparam logic [5:0] OP_ZERO = 6'b101010;
  localparam logic [5:0] OP_ONE  = 6'b111111;
  localparam logic [5:0] OP_NEG1 = 6'b111010;
  localparam logic [5:0] OP_X    = 6'b001100;
  localparam logic [5:0] OP_Y    = 6'b110000;
  localparam logic [5:0] OP_NOTX = 6'b001101;
  localparam logic [5:0] OP_NEGX = 6'b001111;
  localparam logic [5:0] OP_XP1  = 6'b011111;
  localparam logic [5:0] OP_XM1  = 6'b001110;
  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_SUB  = 6'b010011;
  localparam logic [5:0] OP_RSUB = 6'b000111;
  localparam logic [5:0] OP_AND  = 6'b000000;
  localparam logic [5:0] OP_OR   = 6'b010101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/hack_alu_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hack_alu_pipe_if : operand/result handshake bundle for hack_alu_pipe.
// The mul request exists only when ALU_MUL_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
interface hack_alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       op;
`ifdef ALU_MUL_EN
  logic             mul;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             co;
  logic             ov;

  modport master (
    output in_valid, x, y, op,
`ifdef ALU_MUL_EN
    output mul,
`endif
    output out_ready,
    input  in_ready, out_valid, out, zr, ng, co, ov
  );

  modport slave (
    input  in_valid, x, y, op,
`ifdef ALU_MUL_EN
    input  mul,
`endif
    input  out_ready,
    output in_ready, out_valid, out, zr, ng, co, ov
  );
endinterface
`default_nettype wire

// File: rtl/hack_alu_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hack_alu_core : combinational f/no function and flags on preprocessed operands.
// Rev 1.0
// ----------------------------------------------------------------------------
module hack_alu_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] xa_i,
  input  logic [WIDTH-1:0] ya_i,
  input  logic             f_i,
  input  logic             no_i,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o,
  output logic             co_o,
  output logic             ov_o
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_r;

  always_comb begin
    w_sum = {1'b0, xa_i} + {1'b0, ya_i};
    w_r   = f_i ? w_sum[WIDTH-1:0] : (xa_i & ya_i);
    out_o = no_i ? ~w_r : w_r;
    zr_o  = ~|out_o;
    ng_o  = out_o[WIDTH-1];
    // carry/overflow describe the adder itself, so they ignore the final invert
    co_o  = f_i & w_sum[WIDTH];
    ov_o  = f_i & (xa_i[WIDTH-1] == ya_i[WIDTH-1]) & (w_sum[WIDTH-1] != xa_i[WIDTH-1]);
  end

endmodule
`default_nettype wire

// File: rtl/hack_alu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hack_alu_pipe : 2-stage pipelined Hack ALU with valid/ready handshakes.
// ALU_MUL_EN adds a bit-serial unsigned multiply (IDLE/MUL FSM). Rev 1.0
// ----------------------------------------------------------------------------
module hack_alu_pipe
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  hack_alu_pipe_if.slave bus
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] xa_q;
  logic [WIDTH-1:0] ya_q;
  logic             f_q;
  logic             no_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             zr_q;
  logic             ng_q;
  logic             co_q;
  logic             ov_q;

  logic             w_s2_free;
  logic             w_advance;
  logic             w_accept;
  logic             w_in_ready;
  logic             w_idle;
  logic             w_hold;

  logic [WIDTH-1:0] w_xz;
  logic [WIDTH-1:0] w_xa;
  logic [WIDTH-1:0] w_yz;
  logic [WIDTH-1:0] w_ya;
  logic [WIDTH-1:0] w_xa_ld;

  logic [WIDTH-1:0] w_core_out;
  logic             w_core_zr;
  logic             w_core_ng;
  logic             w_core_co;
  logic             w_core_ov;

  logic [WIDTH-1:0] w_res;
  logic             w_zr;
  logic             w_ng;
  logic             w_co;
  logic             w_ov;

  always_comb begin
    w_xz = bus.op[OP_ZX] ? '0 : bus.x;
    w_xa = bus.op[OP_NX] ? ~w_xz : w_xz;
    w_yz = bus.op[OP_ZY] ? '0 : bus.y;
    w_ya = bus.op[OP_NY] ? ~w_yz : w_yz;
  end

  assign w_s2_free  = ~out_valid_q | bus.out_ready;
  assign w_advance  = s1_valid_q & w_s2_free & ~w_hold;
  assign w_in_ready = (~s1_valid_q | w_advance) & w_idle;
  assign w_accept   = bus.in_valid & w_in_ready;

  hack_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .xa_i  (xa_q),
    .ya_i  (ya_q),
    .f_i   (f_q),
    .no_i  (no_q),
    .out_o (w_core_out),
    .zr_o  (w_core_zr),
    .ng_o  (w_core_ng),
    .co_o  (w_core_co),
    .ov_o  (w_core_ov)
  );

`ifdef ALU_MUL_EN
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  alu_state_e         state_q;
  alu_state_e         state_d;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [WIDTH:0]     w_step;
  logic               mul_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      prod_q  <= '0;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        mul_q <= bus.mul;
      end
    end
  end

  // Product register holds {partial high half, unconsumed multiplier bits};
  // each step adds the multiplicand into the high half and shifts right.
  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    w_step  = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept && bus.mul) begin
          state_d = ST_MUL;
          prod_d  = {{WIDTH{1'b0}}, bus.y};
          cnt_d   = '0;
        end
      end
      ST_MUL: begin
        w_step = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, xa_q} : '0);
        prod_d = {w_step, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign w_idle  = (state_q == ST_IDLE);
  assign w_hold  = (state_q == ST_MUL);
  // A multiply keeps the raw multiplicand; the control word is ignored.
  assign w_xa_ld = bus.mul ? bus.x : w_xa;

  always_comb begin
    w_res = w_core_out;
    w_zr  = w_core_zr;
    w_ng  = w_core_ng;
    w_co  = w_core_co;
    w_ov  = w_core_ov;
    if (mul_q) begin
      w_res = prod_q[WIDTH-1:0];
      w_zr  = ~|prod_q[WIDTH-1:0];
      w_ng  = prod_q[WIDTH-1];
      w_co  = |prod_q[2*WIDTH-1:WIDTH];
      w_ov  = 1'b0;
    end
  end
`else
  assign w_idle  = 1'b1;
  assign w_hold  = 1'b0;
  assign w_xa_ld = w_xa;

  always_comb begin
    w_res = w_core_out;
    w_zr  = w_core_zr;
    w_ng  = w_core_ng;
    w_co  = w_core_co;
    w_ov  = w_core_ov;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      xa_q       <= '0;
      ya_q       <= '0;
      f_q        <= 1'b0;
      no_q       <= 1'b0;
    end else if (w_accept) begin
      s1_valid_q <= 1'b1;
      xa_q       <= w_xa_ld;
      ya_q       <= w_ya;
      f_q        <= bus.op[OP_F];
      no_q       <= bus.op[OP_NO];
    end else if (w_advance) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2 only moves when it is free, which keeps a stalled result stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      co_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else if (w_s2_free) begin
      out_valid_q <= w_advance;
      if (w_advance) begin
        out_q <= w_res;
        zr_q  <= w_zr;
        ng_q  <= w_ng;
        co_q  <= w_co;
        ov_q  <= w_ov;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.co        = co_q;
  assign bus.ov        = ov_q;

endmodule
`default_nettype wire

// File: doc/hack_alu_pipe.md
Name: hack_alu_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit combinational Hack-style ALU.
- Same 6-bit control-word semantics (zx,nx,zy,ny,f,no), generalised to WIDTH bits.
- Registered 2-stage datapath with valid/ready handshakes on input and output; adds carry and overflow flags.
- Sits between the register-file read port and the writeback stage of the CPU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/op bundle valid.
- in_ready  output  1  block accepts the bundle this cycle.
- x  input  WIDTH  operand x.
- y  input  WIDTH  operand y.
- op  input  6  control word: op[5]=zx, op[4]=nx, op[3]=zy, op[2]=ny, op[1]=f, op[0]=no.
- mul  input  1  multiply request; present only with ALU_MUL_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out  output  WIDTH  result.
- zr  output  1  out == 0.
- ng  output  1  out[WIDTH-1].
- co  output  1  carry out of adder (f=1), else 0; taken before `no`.
- ov  output  1  signed overflow of adder (f=1), else 0; taken before `no`.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, out_valid=0, out/zr/ng/co/ov=0, FSM=IDLE. in_ready=1 from the first cycle after release.
- Mid-operation reset discards all in-flight bundles.
- Hack function:
  - xa = zx ? 0 : x, then nx ? ~xa : xa; same for y.
  - r = f ? xa+ya (WIDTH bits, carry kept) : xa&ya.
  - out = no ? ~r : r.
- Stage 1 registers xa/ya (preprocessed), f, no on accept (in_valid & in_ready).
- Stage 2 computes r/out/flags from the stage-1 registers and registers them with out_valid.
- Latency: 2 cycles from accept to out_valid. Throughput 1 per cycle with out_ready=1.
- Handshakes:
  - s2_free = !out_valid | out_ready.
  - Stage 1 advances when s1_valid & s2_free.
  - in_ready = (!s1_valid | advance) & FSM==IDLE.
  - out and flags are held stable while out_valid & !out_ready.
- Backpressure: with out_ready=0, exactly 2 bundles are buffered, then in_ready=0. No loss, no duplication, strict in-order delivery.
- Simultaneous accept and advance in the same cycle is legal: stage 1 reloads.
- in_valid with in_ready=0: inputs ignored; the source must hold them.
- Flags: zr/ng are computed on the final out. co/ov are 0 when f=0.

Optional Feature:
- ALU_MUL_EN defined: adds the `mul` port and an FSM {IDLE, MUL}.
  - Accepting a bundle with mul=1 loads stage 1 and enters MUL.
  - A shift-add runs 1 bit per cycle for WIDTH cycles; in_ready=0 throughout and stage 1 is held.
  - On the last cycle the FSM returns to IDLE and the stage-1 bundle is marked complete. It advances to stage 2 under the normal s2_free rule.
  - Result: out = low WIDTH bits of unsigned x*y (op ignored, zx..no ignored). co = |high half; ov=0.
  - Reset in MUL returns to IDLE and discards the bundle.
- ALU_MUL_EN undefined: no mul port, no FSM; behaviour as above.

Decomposition:
- Package hack_alu_pkg holds:
  - op bit indices (OP_ZX..OP_NO).
  - Named opcodes: OP_ZERO=101010, OP_ONE=111111, OP_NEG1=111010, OP_X=001100, OP_Y=110000, OP_NOTX=001101, OP_NEGX=001111, OP_XP1=011111, OP_XM1=001110, OP_ADD=000010, OP_SUB=010011, OP_RSUB=000111, OP_AND=000000, OP_OR=010101.
  - FSM state enum.
- One sub-module, hack_alu_core: combinational f/no/flag function, parametrised by WIDTH, instantiated in stage 2.

Test Plan:
- Reset: assert rst_n=0 with 2 bundles in flight -> out_valid=0 and all outputs 0 immediately; in_ready=1 after release; no stale result appears.
- Basic ops, WIDTH=16, x=0x0005, y=0x0003:
  - OP_ADD -> out=0x0008 two cycles after accept, zr=0, ng=0, co=0, ov=0.
  - OP_SUB -> 0x0002.
  - OP_RSUB -> 0xFFFE, ng=1.
  - OP_AND -> 0x0001.
  - OP_OR -> 0x0007.
- Constants, any x/y:
  - OP_ZERO -> 0x0000, zr=1.
  - OP_ONE -> 0x0001.
  - OP_NEG1 -> 0xFFFF, ng=1.
- Flag boundaries:
  - x=0x7FFF, y=0x0001, OP_ADD -> 0x8000, ng=1, ov=1, co=0.
  - x=0xFFFF, y=0x0001, OP_ADD -> 0x0000, zr=1, co=1, ov=0.
- Backpressure: issue 4 back-to-back OP_XP1 with x=1,2,3,4 and out_ready=0 -> in_ready drops after 2 accepts. Release out_ready -> outputs 2,3,4,5 in order, one per cycle, out stable while stalled.
- ALU_MUL_EN: x=0x0100, y=0x0300, mul=1 -> in_ready=0 for 16 cycles, then out=0x0000, zr=1, co=1. x=0x0012, y=0x0003 -> out=0x0036, co=0.
